gcd_req_master: RTL

GCD_REQ_MASTER -- requirements
Module: gcd_req_master

---
 rtl/gcd_pkg.sv | 25 ++
 rtl/gcd_vec_mem.sv | 30 +++
 rtl/gcd_req_master.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// Shared types and field layout for the GCD request master and its vector memory.
package gcd_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} gcd_state_e;

  localparam int unsigned GCD_W   = 16;
  localparam int unsigned VEC_W   = 48;
  localparam int unsigned REQ_W   = 2 * GCD_W;
  localparam int unsigned A_LSB   = 0;
  localparam int unsigned B_LSB   = GCD_W;
  localparam int unsigned EXP_LSB = 2 * GCD_W;

  // Builds a vector word {expected, b, a}.
  function automatic logic [VEC_W-1:0] pack_vec(input logic [GCD_W-1:0] a,
                                                input logic [GCD_W-1:0] b,
                                                input logic [GCD_W-1:0] expv);
    logic [VEC_W-1:0] v;
    v = '0;
    v[A_LSB +: GCD_W]   = a;
    v[B_LSB +: GCD_W]   = b;
    v[EXP_LSB +: GCD_W] = expv;
    return v;
  endfunction

endpackage

// File: rtl/gcd_vec_mem.sv
// Test-vector store: one write port, async read of operands and of expected result.
module gcd_vec_mem
  import gcd_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = 100,
  parameter int unsigned ADDR_WIDTH  = $clog2(NUM_VECTORS)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [VEC_W-1:0]      wr_data,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic [REQ_W-1:0]      req_data,
  input  logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [GCD_W-1:0]      rsp_exp
);

  logic [VEC_W-1:0] mem_q [NUM_VECTORS];

  // Contents are deliberately not reset; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < NUM_VECTORS)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign req_data = mem_q[req_addr][REQ_W-1:0];
  assign rsp_exp  = mem_q[rsp_addr][EXP_LSB +: GCD_W];

endmodule

// File: rtl/gcd_req_master.sv
// Streams stored operand pairs to a GCD unit and scores its in-order results.
module gcd_req_master
  import gcd_pkg::*;
#(
  parameter int unsigned NUM_VECTORS     = 100,
  parameter int unsigned ADDR_WIDTH      = $clog2(NUM_VECTORS),
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 4096
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [VEC_W-1:0]      load_data,
  input  logic                  start,
  output logic [REQ_W-1:0]      req_msg,
  output logic                  req_val,
  input  logic                  req_rdy,
  input  logic [GCD_W-1:0]      resp_msg,
  input  logic                  resp_val,
  output logic                  resp_rdy,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [GCD_W-1:0]      err_count,
  output logic [ADDR_WIDTH-1:0] first_err_idx,
  output logic                  timeout
);

  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_VECTORS - 1);
  localparam logic [GCD_W-1:0]      ERR_MAX  = '1;

  gcd_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] req_idx_q, req_idx_d;
  logic [ADDR_WIDTH-1:0] rsp_idx_q, rsp_idx_d;
  logic [ADDR_WIDTH-1:0] first_err_idx_q, first_err_idx_d;
  logic [OUT_W-1:0]      outstanding_q, outstanding_d;
  logic [GCD_W-1:0]      err_count_q, err_count_d;
  logic                  timeout_q, timeout_d;
  logic [WD_W-1:0]       wdog_q, wdog_d;
  logic [GCD_W-1:0]      exp_msg;
  logic                  req_fire, resp_fire, rsp_ok;

  gcd_vec_mem #(
    .NUM_VECTORS (NUM_VECTORS),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_mem (
    .clk      (clk),
    .wr_en    (load_en),
    .wr_addr  (load_addr),
    .wr_data  (load_data),
    .req_addr (req_idx_q),
    .req_data (req_msg),
    .rsp_addr (rsp_idx_q),
    .rsp_exp  (exp_msg)
  );

  assign busy          = (state_q == RUN) || (state_q == DRAIN);
  assign done          = (state_q == DONE);
  assign pass          = done && (err_count_q == '0) && !timeout_q;
  assign req_val       = (state_q == RUN) && (outstanding_q < OUT_W'(MAX_OUTSTANDING));
  assign resp_rdy      = busy;
  assign err_count     = err_count_q;
  assign first_err_idx = first_err_idx_q;
  assign timeout       = timeout_q;

  assign req_fire  = req_val && req_rdy;
  assign resp_fire = resp_val && resp_rdy;
  // A response with nothing in flight is scored as an error but consumes no vector.
  assign rsp_ok    = resp_fire && (outstanding_q != '0);

  always_comb begin
    state_d         = state_q;
    req_idx_d       = req_idx_q;
    rsp_idx_d       = rsp_idx_q;
    first_err_idx_d = first_err_idx_q;
    outstanding_d   = outstanding_q;
    err_count_d     = err_count_q;
    timeout_d       = timeout_q;
    wdog_d          = wdog_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d         = RUN;
          req_idx_d       = '0;
          rsp_idx_d       = '0;
          first_err_idx_d = '0;
          outstanding_d   = '0;
          err_count_d     = '0;
          timeout_d       = 1'b0;
          wdog_d          = '0;
        end
      end
      RUN, DRAIN: begin
        if (req_fire) begin
          if (req_idx_q == LAST_IDX) state_d = DRAIN;
          else                       req_idx_d = req_idx_q + ADDR_WIDTH'(1);
        end

        if (resp_fire && (!rsp_ok || (resp_msg != exp_msg))) begin
          if (err_count_q != ERR_MAX) err_count_d = err_count_q + GCD_W'(1);
          if (err_count_q == '0)      first_err_idx_d = rsp_idx_q;
        end

        if (rsp_ok) begin
          if (rsp_idx_q == LAST_IDX) state_d = DONE;
          else                       rsp_idx_d = rsp_idx_q + ADDR_WIDTH'(1);
        end

        if (req_fire && !rsp_ok)      outstanding_d = outstanding_q + OUT_W'(1);
        else if (!req_fire && rsp_ok) outstanding_d = outstanding_q - OUT_W'(1);

        // Watchdog counts only cycles where neither channel moves.
        if (req_fire || resp_fire) begin
          wdog_d = '0;
        end else if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      req_idx_q       <= '0;
      rsp_idx_q       <= '0;
      first_err_idx_q <= '0;
      outstanding_q   <= '0;
      err_count_q     <= '0;
      timeout_q       <= 1'b0;
      wdog_q          <= '0;
    end else begin
      state_q         <= state_d;
      req_idx_q       <= req_idx_d;
      rsp_idx_q       <= rsp_idx_d;
      first_err_idx_q <= first_err_idx_d;
      outstanding_q   <= outstanding_d;
      err_count_q     <= err_count_d;
      timeout_q       <= timeout_d;
      wdog_q          <= wdog_d;
    end
  end

endmodule
